// File: rtl/round_controller.sv
// Game-round sequencer: runs reaction rounds against an external ms timer, scores hits, counts misses.
// Latency: one state transition per clock; ARM is exactly 1 cycle, GAP is GAP_MS*CLKS_PER_MS cycles.
// Backpressure: none; start/pause/hit are single-cycle pulses and are dropped in states that ignore them.
module round_controller #(
  parameter int MAX_MS      = 4095,
  parameter int CLKS_PER_MS = 50000,
  parameter int NUM_ROUNDS  = 10,
  parameter int MAX_MISSES  = 3,
  parameter int BASE_MS     = 2000,
  parameter int STEP_MS     = 100,
  parameter int MIN_MS      = 500,
  parameter int GAP_MS      = 1000,
  localparam int W          = $clog2(MAX_MS),
  localparam int RW         = $clog2(NUM_ROUNDS + 1),
  localparam int MW         = $clog2(MAX_MISSES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          hit,
  input  logic [1:0]    difficulty_sel,
  input  logic [W-1:0]  timer_value,
  input  logic          timer_end_reached,
  output logic          timer_reset,
  output logic          timer_enable,
  output logic [1:0]    timer_difficulty,
  output logic [W-1:0]  timer_end_value,
  output logic [RW-1:0] round,
  output logic [RW-1:0] score,
  output logic [MW-1:0] misses,
  output logic [W-1:0]  reaction_ms,
  output logic          target_active,
  output logic          game_over,
  output logic [2:0]    state
);

  localparam int GAP_CYC = GAP_MS * CLKS_PER_MS;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  // Threshold at which one more STEP_MS reduction still lands at or above the floor.
  localparam logic [W:0] STEP_THRESH = (W + 1)'(MIN_MS + STEP_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [RW-1:0] score_q, score_d;
  logic [MW-1:0] misses_q, misses_d;
  logic [W-1:0]  react_q, react_d;
  logic [1:0]    diff_q, diff_d;
  logic [W-1:0]  end_q, end_d;
  logic [GW-1:0] gap_q, gap_d;

  // State and game registers; reset aborts any game in progress with nothing retained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      react_q  <= '0;
      diff_q   <= '0;
      end_q    <= W'(BASE_MS);
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      react_q  <= react_d;
      diff_q   <= diff_d;
      end_q    <= end_d;
      gap_q    <= gap_d;
    end
  end

  // Next-state and datapath updates; in RUN a hit outranks a timeout, which outranks pause.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    score_d  = score_q;
    misses_d = misses_q;
    react_d  = react_q;
    diff_d   = diff_q;
    end_d    = end_q;
    gap_d    = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          diff_d   = (difficulty_sel == 2'd3) ? 2'd2 : difficulty_sel;
          round_d  = RW'(1);
          score_d  = '0;
          misses_d = '0;
          react_d  = '0;
          end_d    = W'(BASE_MS);
          state_d  = S_ARM;
        end
      end

      // Single cycle with timer_reset high so the timer starts every round from zero.
      S_ARM: state_d = S_RUN;

      S_RUN: begin
        if (hit) begin
          score_d = score_q + RW'(1);
          react_d = timer_value;
          state_d = S_GAP;
        end else if (timer_end_reached) begin
          misses_d = misses_q + MW'(1);
          state_d  = (misses_q == MW'(MAX_MISSES - 1)) ? S_DONE : S_GAP;
        end else if (pause) begin
          state_d = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (pause) state_d = S_RUN;
      end

      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          if (round_q == RW'(NUM_ROUNDS)) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + RW'(1);
            // Compare first so the subtraction can never wrap below the floor.
            end_d   = ({1'b0, end_q} >= STEP_THRESH) ? (end_q - W'(STEP_MS)) : W'(MIN_MS);
            state_d = S_ARM;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode; PAUSED drops both reset and enable so the timer holds its count.
  always_comb begin
    timer_reset   = (state_q == S_IDLE) || (state_q == S_ARM) ||
                    (state_q == S_GAP)  || (state_q == S_DONE);
    timer_enable  = (state_q == S_RUN);
    target_active = (state_q == S_RUN);
    game_over     = (state_q == S_DONE);
  end

  assign state            = state_q;
  assign round            = round_q;
  assign score            = score_q;
  assign misses           = misses_q;
  assign reaction_ms      = react_q;
  assign timer_difficulty = diff_q;
  assign timer_end_value  = end_q;

endmodule
